// File: rtl/rope_gfx_pkg.sv
// Shared definitions for the rope display graphics path.
// Holds default coordinate/colour widths, the default node colours, and
// helpers for slicing the packed node-position buses and sizing the
// squared-distance datapath.
package rope_gfx_pkg;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 3;

  localparam logic [COLOR_W-1:0] NODE_COLOR   = 3'b101;
  localparam logic [COLOR_W-1:0] ANCHOR_COLOR = 3'b100;
  localparam logic [COLOR_W-1:0] BG_COLOR     = 3'b010;

  // Upper bounds the slice helper can handle; callers cast into this width.
  localparam int MAX_NODES   = 64;
  localparam int MAX_COORD_W = 16;
  localparam int PACK_W      = MAX_NODES * MAX_COORD_W;

  // Returns coordinate idx from a packed bus whose fields are coord_w wide.
  function automatic logic [MAX_COORD_W-1:0] node_coord(
    input logic [PACK_W-1:0] packed_v,
    input int                idx,
    input int                coord_w
  );
    logic [MAX_COORD_W-1:0] mask;
    mask       = (MAX_COORD_W'(1) << coord_w) - MAX_COORD_W'(1);
    node_coord = MAX_COORD_W'(packed_v >> (idx * coord_w)) & mask;
  endfunction

  // dx*dx + dy*dy with signed (coord_w+1)-bit deltas never exceeds this width.
  function automatic int d2_width(input int coord_w);
    return 2 * coord_w + 3;
  endfunction

endpackage

// File: rtl/node_hit_stage.sv
// Per-node hit test, two pipeline stages.
//   S1: signed deltas between the pixel and this node's centre.
//   S2: squared distance compared against the disc (or ring) limits.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   pix_x, pix_y      pixel coordinates (S1 input)
//   node_x, node_y    node centre from the frame snapshot (S1 input)
//   ring_mode         draw mode aligned with the S1 deltas (1 = outline only)
//   hit               registered S2 result: pixel covered by this node
module node_hit_stage #(
  parameter int COORD_W = 10,
  parameter int RADIUS  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [COORD_W-1:0] node_x,
  input  logic [COORD_W-1:0] node_y,
  input  logic               ring_mode,
  output logic               hit
);
  import rope_gfx_pkg::d2_width;

  localparam int DW   = COORD_W + 1;
  localparam int D2_W = d2_width(COORD_W);
  localparam logic [D2_W-1:0] R_SQ    = D2_W'(RADIUS * RADIUS);
  localparam logic [D2_W-1:0] R_IN_SQ = D2_W'((RADIUS - 1) * (RADIUS - 1));

  logic signed [DW-1:0]   dx, dy;
  logic signed [2*DW-1:0] dx_sq, dy_sq;
  logic [D2_W-1:0]        d2;
  logic                   in_disc, in_hole;

  // NOTE: synchronous reset inside the clocked block, and non-blocking
  // assignments for every register so all stages update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      dx  <= '0;
      dy  <= '0;
      hit <= 1'b0;
    end else begin
      // Zero-extend before subtracting so pixels left of / above the node
      // give a negative delta instead of a large unsigned wrap.
      dx  <= $signed({1'b0, pix_x}) - $signed({1'b0, node_x});
      dy  <= $signed({1'b0, pix_y}) - $signed({1'b0, node_y});
      hit <= in_disc & ~(ring_mode & in_hole);
    end
  end

  // NOTE: every combinational output gets a value on every path, so no latch.
  always_comb begin
    dx_sq   = dx * dx;
    dy_sq   = dy * dy;
    d2      = D2_W'($unsigned(dx_sq)) + D2_W'($unsigned(dy_sq));
    in_disc = (d2 <= R_SQ);
    in_hole = (d2 <= R_IN_SQ);
  end

endmodule

// File: rtl/rope_node_renderer.sv
// Pipelined pixel colouriser for the rope display.
// Tests each pixel against N_NODES circular nodes (positions snapshotted at
// frame start) and emits the colour three cycles later.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   frame_start       one-cycle pulse: snapshot node positions, roll hit counter
//   mode              0 = filled discs, 1 = rings
//   video_on          pixel is visible
//   pix_x, pix_y      current pixel
//   nodes_x, nodes_y  packed node positions, node i at [i*COORD_W +: COORD_W]
//   graph_rgb         pixel colour (3-cycle latency)
//   hit, hit_node     covered flag and lowest covering node (0 when no hit)
//   frame_hit_count   hit pixels seen during the previous frame
module rope_node_renderer #(
  parameter int                 N_NODES      = 20,
  parameter int                 COORD_W      = rope_gfx_pkg::COORD_W,
  parameter int                 RADIUS       = 10,
  parameter int                 COLOR_W      = rope_gfx_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] NODE_COLOR   = rope_gfx_pkg::NODE_COLOR,
  parameter logic [COLOR_W-1:0] ANCHOR_COLOR = rope_gfx_pkg::ANCHOR_COLOR,
  parameter logic [COLOR_W-1:0] BG_COLOR     = rope_gfx_pkg::BG_COLOR,
  parameter int                 CNT_W        = 20,
  localparam int                IDX_W        = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       mode,
  input  logic                       video_on,
  input  logic [COORD_W-1:0]         pix_x,
  input  logic [COORD_W-1:0]         pix_y,
  input  logic [N_NODES*COORD_W-1:0] nodes_x,
  input  logic [N_NODES*COORD_W-1:0] nodes_y,
  output logic [COLOR_W-1:0]         graph_rgb,
  output logic                       hit,
  output logic [IDX_W-1:0]           hit_node,
  output logic [CNT_W-1:0]           frame_hit_count
);
  import rope_gfx_pkg::node_coord;
  import rope_gfx_pkg::PACK_W;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_NODES*COORD_W-1:0] shadow_x, shadow_y;
  logic [N_NODES-1:0]         hit_vec;
  logic                       video_on_d1, video_on_d2, mode_d1;
  logic [CNT_W-1:0]           acc;

  logic                       enc_any, hit_next;
  logic [IDX_W-1:0]           enc_idx, node_next;
  logic [COLOR_W-1:0]         rgb_next;

  // Snapshot: pixels in the frame_start cycle still see the old positions
  // because S1 reads the shadow registers before they update.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_x <= '0;
      shadow_y <= '0;
    end else if (frame_start) begin
      shadow_x <= nodes_x;
      shadow_y <= nodes_y;
    end
  end

  for (genvar i = 0; i < N_NODES; i++) begin : g_node
    logic [COORD_W-1:0] sx, sy;
    assign sx = COORD_W'(node_coord(PACK_W'(shadow_x), i, COORD_W));
    assign sy = COORD_W'(node_coord(PACK_W'(shadow_y), i, COORD_W));

    node_hit_stage #(
      .COORD_W (COORD_W),
      .RADIUS  (RADIUS)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .node_x    (sx),
      .node_y    (sy),
      .ring_mode (mode_d1),
      .hit       (hit_vec[i])
    );
  end

  // Side-band delay line keeping video_on and mode aligned with the stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      video_on_d1 <= 1'b0;
      video_on_d2 <= 1'b0;
      mode_d1     <= 1'b0;
    end else begin
      video_on_d1 <= video_on;
      video_on_d2 <= video_on_d1;
      mode_d1     <= mode;
    end
  end

  // Priority encoder (scan high to low so the lowest index wins) + colour mux.
  always_comb begin
    enc_any = 1'b0;
    enc_idx = '0;
    for (int i = N_NODES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        enc_any = 1'b1;
        enc_idx = IDX_W'(i);
      end
    end
    hit_next  = video_on_d2 & enc_any;
    node_next = hit_next ? enc_idx : '0;
    if (!video_on_d2)       rgb_next = '0;
    else if (!hit_next)     rgb_next = BG_COLOR;
    else if (enc_idx == '0) rgb_next = ANCHOR_COLOR;
    else                    rgb_next = NODE_COLOR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      graph_rgb <= '0;
      hit       <= 1'b0;
      hit_node  <= '0;
    end else begin
      graph_rgb <= rgb_next;
      hit       <= hit_next;
      hit_node  <= node_next;
    end
  end

  // Counts registered hit outputs; a hit in the frame_start cycle still
  // belongs to the frame being closed.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc             <= '0;
      frame_hit_count <= '0;
    end else if (frame_start) begin
      frame_hit_count <= (hit && acc != CNT_MAX) ? acc + CNT_W'(1) : acc;
      acc             <= '0;
    end else if (hit && acc != CNT_MAX) begin
      acc <= acc + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rope_node_renderer.sv
// Directed bench for rope_node_renderer with default parameters
// (20 nodes, 10-bit coordinates, radius 10).
module tb_rope_node_renderer;
  localparam int N = 20;
  localparam int W = 10;
  localparam logic [2:0] BG   = 3'b010;
  localparam logic [2:0] ANCH = 3'b100;
  localparam logic [2:0] NODE = 3'b101;

  logic         clk = 1'b0;
  logic         reset, frame_start, mode, video_on;
  logic [W-1:0] pix_x, pix_y;
  logic [N*W-1:0] nodes_x, nodes_y;
  logic [2:0]   graph_rgb;
  logic         hit;
  logic [4:0]   hit_node;
  logic [19:0]  frame_hit_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rope_node_renderer dut (
    .clk             (clk),
    .reset           (reset),
    .frame_start     (frame_start),
    .mode            (mode),
    .video_on        (video_on),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .nodes_x         (nodes_x),
    .nodes_y         (nodes_y),
    .graph_rgb       (graph_rgb),
    .hit             (hit),
    .hit_node        (hit_node),
    .frame_hit_count (frame_hit_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_px(input string tag, input logic eh, input logic [4:0] en,
                          input logic [2:0] er);
    check({tag, ".hit"}, 32'(hit), 32'(eh));
    check({tag, ".node"}, 32'(hit_node), 32'(en));
    check({tag, ".rgb"}, 32'(graph_rgb), 32'(er));
  endtask

  task automatic set_node(input int i, input int x, input int y);
    nodes_x[i*W +: W] = W'(x);
    nodes_y[i*W +: W] = W'(y);
  endtask

  task automatic far_all();
    for (int i = 0; i < N; i++) set_node(i, 700, 500);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input logic von);
    @(negedge clk);
    pix_x    = W'(x);
    pix_y    = W'(y);
    video_on = von;
  endtask

  // Present a pixel and wait until its result is on the outputs.
  task automatic look(input int x, input int y, input logic von);
    drive(x, y, von);
    repeat (3) step();
  endtask

  task automatic pulse_fs();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic scan_window(input logic von);
    for (int y = 220; y <= 260; y++)
      for (int x = 300; x <= 340; x++)
        drive(x, y, von);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    mode        = 1'b0;
    video_on    = 1'b1;
    pix_x       = W'(50);
    pix_y       = W'(50);
    nodes_x     = '0;
    nodes_y     = '0;
    far_all();

    // Reset state and first-pixel latency; shadow is all zeros.
    repeat (5) step();
    check("rst.rgb", 32'(graph_rgb), 32'(0));
    check("rst.hit", 32'(hit), 32'(0));
    check("rst.count", 32'(frame_hit_count), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    check("rst.lat2", 32'(graph_rgb), 32'(0));
    step();
    check_px("rst.bg", 1'b0, 5'd0, BG);
    look(3, 4, 1'b1);
    check_px("rst.origin", 1'b1, 5'd0, ANCH);

    // Node 5 fill: boundary d2=100 hits, d2=113 misses; exact 3-cycle latency.
    far_all();
    set_node(5, 100, 100);
    pulse_fs();
    look(107, 108, 1'b1);
    step();
    check_px("fill.d2_113", 1'b0, 5'd0, BG);
    drive(106, 108, 1'b1);
    step();
    check("fill.lat1", 32'(graph_rgb), 32'(BG));
    step();
    check("fill.lat2", 32'(graph_rgb), 32'(BG));
    step();
    check_px("fill.d2_100", 1'b1, 5'd5, NODE);

    // Ring mode on the same node.
    mode = 1'b1;
    look(110, 100, 1'b1);
    check_px("ring.edge", 1'b1, 5'd5, NODE);
    look(100, 100, 1'b1);
    check_px("ring.centre", 1'b0, 5'd0, BG);
    look(109, 100, 1'b1);
    check_px("ring.d2_81", 1'b0, 5'd0, BG);
    mode = 1'b0;

    // Edge coordinates and priority between overlapping nodes.
    far_all();
    set_node(0, 2, 2);
    set_node(1, 5, 2);
    pulse_fs();
    look(639, 2, 1'b1);
    check_px("edge.far_x", 1'b0, 5'd0, BG);
    look(4, 2, 1'b1);
    check_px("edge.overlap", 1'b1, 5'd0, ANCH);
    look(14, 2, 1'b1);
    check_px("edge.node1", 1'b1, 5'd1, NODE);
    look(0, 0, 1'b1);
    check_px("edge.origin", 1'b1, 5'd0, ANCH);

    // Position changes ignored until frame_start; frame_start pixel sees old.
    set_node(0, 300, 2);
    set_node(1, 305, 2);
    look(4, 2, 1'b1);
    check_px("snap.held", 1'b1, 5'd0, ANCH);
    @(negedge clk);
    frame_start = 1'b1;
    step();
    @(negedge clk);
    frame_start = 1'b0;
    step();
    step();
    check_px("snap.fs_old", 1'b1, 5'd0, ANCH);
    step();
    check_px("snap.new", 1'b0, 5'd0, BG);

    // Hit counter over a window around a single node: 317 lattice points.
    far_all();
    set_node(0, 320, 240);
    look(0, 0, 1'b1);
    pulse_fs();
    scan_window(1'b1);
    drive(0, 0, 1'b1);
    repeat (4) step();
    pulse_fs();
    check("count.disc", 32'(frame_hit_count), 32'(317));

    // video_on=0: black output, nothing counted.
    scan_window(1'b0);
    look(320, 240, 1'b0);
    check_px("blank", 1'b0, 5'd0, 3'd0);
    check("count.hold", 32'(frame_hit_count), 32'(317));
    pulse_fs();
    check("count.blank", 32'(frame_hit_count), 32'(0));

    // Mid-frame reset flushes outputs and clears the snapshot.
    look(320, 240, 1'b1);
    check_px("mid.pre", 1'b1, 5'd0, ANCH);
    @(negedge clk);
    reset = 1'b1;
    step();
    check_px("mid.rst", 1'b0, 5'd0, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    look(320, 240, 1'b1);
    check_px("mid.shadow_gone", 1'b0, 5'd0, BG);
    look(3, 4, 1'b1);
    check_px("mid.origin", 1'b1, 5'd0, ANCH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
